// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller: state encoding
// and slice width.
package nibble_serial_adder_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Request/result bundle between a requester (master) and the nibble-serial
// adder controller (slave).
interface nibble_serial_adder_ctrl_if
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
);
    localparam int W = NIBBLE_W * NIBBLES;

    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output start, sub, cin, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, cin, a, b,
        output busy, done, sum, cout, ovf
    );

endinterface

// File: rtl/nibble_serial_adder_ctrl_adder4_nibble.sv
// Combinational 4-bit ripple adder slice shared across all nibbles of an
// operation.
module adder4_nibble (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide add/subtract sequencer: one 4-bit adder is reused over NIBBLES cycles,
// least significant nibble first, with a registered carry between slices.
//
// state  | meaning
// IDLE   | waiting for start; result registers hold the last completion
// RUN    | one nibble per cycle, idx counts 0..NIBBLES-1
// DONE   | one-cycle completion; start here chains straight into RUN
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    nibble_serial_adder_ctrl_if.slave  bus
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e             state_q,   state_d;
    logic [W-1:0]       op_a_q,    op_a_d;
    logic [W-1:0]       op_b_q,    op_b_d;
    logic [W-1:0]       partial_q, partial_d;
    logic [IDX_W-1:0]   idx_q,     idx_d;
    logic               carry_q,   carry_d;
    logic               a_msb_q,   a_msb_d;
    logic               b_msb_q,   b_msb_d;
    logic [W-1:0]       sum_q,     sum_d;
    logic               cout_q,    cout_d;
    logic               ovf_q,     ovf_d;

    logic [NIBBLE_W-1:0] nib_a;
    logic [NIBBLE_W-1:0] nib_b;
    logic [NIBBLE_W-1:0] nib_s;
    logic                nib_co;
    logic [W-1:0]        op_b_in;
    logic                accept;

    assign nib_a   = op_a_q[idx_q*NIBBLE_W +: NIBBLE_W];
    assign nib_b   = op_b_q[idx_q*NIBBLE_W +: NIBBLE_W];
    assign op_b_in = bus.sub ? ~bus.b : bus.b;
    assign accept  = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));

    adder4_nibble u_adder (
        .a  (nib_a),
        .b  (nib_b),
        .ci (carry_q),
        .s  (nib_s),
        .co (nib_co)
    );

    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        partial_d = partial_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        a_msb_d   = a_msb_q;
        b_msb_d   = b_msb_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;

        case (state_q)
            S_IDLE: ;
            S_RUN: begin
                partial_d[idx_q*NIBBLE_W +: NIBBLE_W] = nib_s;
                carry_d = nib_co;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    // partial_d already carries the final nibble here
                    state_d = S_DONE;
                    idx_d   = '0;
                    sum_d   = partial_d;
                    cout_d  = nib_co;
                    ovf_d   = (a_msb_q == b_msb_q) && (partial_d[W-1] != a_msb_q);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            state_d = S_RUN;
            op_a_d  = bus.a;
            op_b_d  = op_b_in;
            carry_d = bus.sub ? 1'b1 : bus.cin;
            idx_d   = '0;
            a_msb_d = bus.a[W-1];
            b_msb_d = op_b_in[W-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_a_q    <= '0;
            op_b_q    <= '0;
            partial_q <= '0;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            a_msb_q   <= 1'b0;
            b_msb_q   <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            partial_q <= partial_d;
            idx_q     <= idx_d;
            carry_q   <= carry_d;
            a_msb_q   <= a_msb_d;
            b_msb_q   <= b_msb_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl with NIBBLES=4 (16-bit operands).
module tb_nibble_serial_adder_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    nibble_serial_adder_ctrl_if #(.NIBBLES(4)) bus ();

    nibble_serial_adder_ctrl #(.NIBBLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request and waits (bounded) for done; returns what was seen.
    task automatic run_op(input logic [15:0] a_i, input logic [15:0] b_i,
                          input logic sub_i, input logic cin_i,
                          output logic [15:0] s_o, output logic c_o,
                          output logic v_o, output int lat_o, output int busy_o);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a_i;
        bus.b     = b_i;
        bus.sub   = sub_i;
        bus.cin   = cin_i;
        @(negedge clk);
        bus.start = 1'b0;
        lat_o  = 1;
        busy_o = 0;
        while (bus.done !== 1'b1 && lat_o < 20) begin
            if (bus.busy === 1'b1) busy_o++;
            @(negedge clk);
            lat_o++;
        end
        s_o = bus.sum;
        c_o = bus.cout;
        v_o = bus.ovf;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== 16'h0000 ||
            bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b ovf=%b, want 0 0 0000 0 0",
                     bus.busy, bus.done, bus.sum, bus.cout, bus.ovf);
        end
        rst = 1'b0;
    endtask

    task automatic test_add_basic();
        logic [15:0] s;
        logic c, v;
        int lat, bsy;
        run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, s, c, v, lat, bsy);
        checks++;
        if (s !== 16'h2233 || c !== 1'b0 || v !== 1'b0) begin
            errors++;
            $display("FAIL add_basic: sum=%h cout=%b ovf=%b, want 2233 0 0", s, c, v);
        end
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL add_latency: got %0d edges, want 5", lat);
        end
        checks++;
        if (bsy !== 4) begin
            errors++;
            $display("FAIL add_busy_cycles: got %0d, want 4", bsy);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.sum !== 16'h2233) begin
            errors++;
            $display("FAIL done_one_cycle: done=%b sum=%h, want 0 2233", bus.done, bus.sum);
        end
    endtask

    task automatic test_add_carry_ovf();
        logic [15:0] s;
        logic c, v;
        int lat, bsy;
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, s, c, v, lat, bsy);
        checks++;
        if (s !== 16'h0000 || c !== 1'b1 || v !== 1'b0) begin
            errors++;
            $display("FAIL add_ripple_carry: sum=%h cout=%b ovf=%b, want 0000 1 0", s, c, v);
        end
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, s, c, v, lat, bsy);
        checks++;
        if (s !== 16'h8000 || c !== 1'b0 || v !== 1'b1) begin
            errors++;
            $display("FAIL add_overflow: sum=%h cout=%b ovf=%b, want 8000 0 1", s, c, v);
        end
    endtask

    task automatic test_sub();
        logic [15:0] s;
        logic c, v;
        int lat, bsy;
        run_op(16'h0004, 16'h0005, 1'b1, 1'b0, s, c, v, lat, bsy);
        checks++;
        if (s !== 16'hFFFF || c !== 1'b0 || v !== 1'b0) begin
            errors++;
            $display("FAIL sub_borrow: sum=%h cout=%b ovf=%b, want FFFF 0 0", s, c, v);
        end
        run_op(16'h8000, 16'h0001, 1'b1, 1'b0, s, c, v, lat, bsy);
        checks++;
        if (s !== 16'h7FFF || c !== 1'b1 || v !== 1'b1) begin
            errors++;
            $display("FAIL sub_overflow: sum=%h cout=%b ovf=%b, want 7FFF 1 1", s, c, v);
        end
        run_op(16'h0004, 16'h0005, 1'b1, 1'b1, s, c, v, lat, bsy);
        checks++;
        if (s !== 16'hFFFF || c !== 1'b0) begin
            errors++;
            $display("FAIL sub_ignores_cin: sum=%h cout=%b, want FFFF 0", s, c);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_s;
        int n;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h0004;
        bus.b     = 16'h0000;
        bus.sub   = 1'b0;
        bus.cin   = 1'b0;
        for (int i = 0; i < 32; i++) begin
            exp_s = 16'h0004 + 16'(i % 16) + 16'(i / 16);
            @(negedge clk);
            bus.start = 1'b0;
            checks++;
            if (bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b_accept[%0d]: busy=%b, want 1", i, bus.busy);
            end
            n = 0;
            while (bus.done !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (bus.done !== 1'b1 || bus.sum !== exp_s || bus.cout !== 1'b0) begin
                errors++;
                $display("FAIL b2b_sum[%0d]: done=%b sum=%h cout=%b, want 1 %h 0",
                         i, bus.done, bus.sum, bus.cout, exp_s);
            end
            if (i < 31) begin
                bus.start = 1'b1;
                bus.b     = 16'((i + 1) % 16);
                bus.cin   = ((i + 1) / 16) != 0;
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [15:0] prev;
        int dones;
        prev = bus.sum;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h1234;
        bus.b     = 16'h0FFF;
        bus.sub   = 1'b0;
        bus.cin   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h0000;
        bus.b     = 16'h0000;
        bus.sub   = 1'b1;
        checks++;
        if (bus.busy !== 1'b1 || bus.sum !== prev) begin
            errors++;
            $display("FAIL hold_during_run: busy=%b sum=%h, want 1 %h", bus.busy, bus.sum, prev);
        end
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done === 1'b1) begin
                dones++;
                checks++;
                if (bus.sum !== 16'h2233) begin
                    errors++;
                    $display("FAIL inputs_not_resampled: sum=%h, want 2233", bus.sum);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL start_ignored_when_busy: %0d done pulses, want 1", dones);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] s;
        logic c, v;
        int lat, bsy, dones;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h1111;
        bus.b     = 16'h1111;
        bus.sub   = 1'b0;
        bus.cin   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== 16'h0000 ||
            bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run: busy=%b done=%b sum=%h cout=%b ovf=%b, want 0 0 0000 0 0",
                     bus.busy, bus.done, bus.sum, bus.cout, bus.ovf);
        end
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL reset_aborts: %0d busy/done cycles after reset, want 0", dones);
        end
        run_op(16'h1111, 16'h1111, 1'b0, 1'b0, s, c, v, lat, bsy);
        checks++;
        if (s !== 16'h2222 || c !== 1'b0 || v !== 1'b0 || lat !== 5) begin
            errors++;
            $display("FAIL after_reset_op: sum=%h cout=%b ovf=%b lat=%0d, want 2222 0 0 5",
                     s, c, v, lat);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.cin   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        test_reset();
        test_add_basic();
        test_add_carry_ovf();
        test_sub();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that performs a wide add or subtract by time-multiplexing one 4-bit ripple adder over NIBBLES clock cycles, least significant nibble first.
- A registered carry links successive nibbles.
- Serves as the controller layer above the team's 4-bit adder datapath. Lets one small adder implement 8/16/32-bit arithmetic for the lab's counter and ALU exercises.

Parameters:
NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES (legal 2..8).

Ports:
clk      input   1    system clock, rising edge
rst      input   1    synchronous reset, active-high
start    input   1    request; accepted only when busy=0
sub      input   1    0: a+b+cin; 1: a-b (a + ~b + 1; cin ignored)
cin      input   1    carry-in for add mode
a        input   W    operand A, sampled on accepted start
b        input   W    operand B, sampled on accepted start
busy     output  1    operation in progress
done     output  1    one-cycle completion pulse
sum      output  W    result, held until next completion
cout     output  1    carry out of MSB nibble (sub: 1 = no borrow)
ovf      output  1    signed overflow of the W-bit result

Behaviour:
- Reset (sync, active-high, has priority over everything):
  - state=IDLE.
  - busy=0, done=0, sum=0, cout=0, ovf=0.
  - Internal operand/partial registers, nibble index and carry are all cleared.
  - Reset mid-RUN aborts the operation; no done pulse follows.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 -> RUN.
  - RUN: stays for exactly NIBBLES cycles. When the index reaches NIBBLES-1 -> DONE.
  - DONE: lasts one cycle. start=1 -> RUN (back-to-back); else -> IDLE.
- Acceptance edge (start=1 while state is IDLE or DONE):
  - Latch opA=a and opB = sub ? ~b : b.
  - carry = sub ? 1 : cin.
  - idx=0.
  - Latch sign bits a[W-1] and opB[W-1] for overflow.
- start while busy=1 is ignored: no effect, no queueing.
- RUN, each edge with idx=k:
  - Adder inputs are opA[4k+3:4k], opB[4k+3:4k] and carry.
  - Store the nibble result in partial[4k+3:4k].
  - carry <= adder carry-out; idx <= k+1.
- Transition RUN -> DONE (same edge as nibble NIBBLES-1):
  - sum <= full partial result, including the final nibble.
  - cout <= final carry.
  - ovf <= (A_msb == opB_msb) && (result_msb != A_msb).
  - done <= 1 for exactly one cycle.
- Timing: busy=1 exactly when state=RUN. If start is sampled at edge 0, busy is high for cycles 1..NIBBLES and done is high in cycle NIBBLES+1. Start-to-done latency is NIBBLES+1 edges.
- sum/cout/ovf:
  - Change only on the RUN->DONE edge or on reset.
  - Hold their values in DONE, in IDLE, and during a following RUN.
  - Partial nibbles are never visible on sum.
- Wrap-around: results are modulo 2^W; the carry shows in cout.
- Inputs a/b/sub/cin may change freely while busy; they are not resampled.

Decomposition:
- Shared package holds:
  - the state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - a NIBBLE_W=4 constant.
- Natural sub-module: adder4_nibble, a combinational 4-bit adder with ports (a[3:0], b[3:0], ci, s[3:0], co). Instantiated once; the controller owns all registers.

Test Plan:
1. NIBBLES=4, add, a=16'h1234, b=16'h0FFF, cin=0 -> sum=16'h2233, cout=0, ovf=0. busy high 4 cycles; done pulse on the 5th edge after start.
2. Add, a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1, ovf=0 (carry ripples through all 4 nibbles). Then a=16'h7FFF, b=16'h0001 -> sum=16'h8000, cout=0, ovf=1.
3. Sub, a=16'h0004, b=16'h0005 -> sum=16'hFFFF, cout=0, ovf=0. Then a=16'h8000, b=16'h0001 -> sum=16'h7FFF, cout=1, ovf=1.
4. Sweep, add mode, a=16'h0004, b=0..15, cin=0 then cin=1 -> each sum=4+b+cin, cout=0. Issue each start in the DONE cycle of the previous operation: back-to-back accepted with no IDLE gap.
5. Busy and input holding:
   - Assert start again on the 2nd busy cycle -> ignored; exactly one done pulse.
   - Change a/b mid-RUN -> result unaffected.
6. Reset mid-operation:
   - Assert rst in the 3rd RUN cycle of a=16'h1111, b=16'h1111 -> next cycle busy=0, done=0, sum=0, cout=0, ovf=0, and no done pulse.
   - A fresh start afterwards computes 16'h2222 correctly.
